mdio_phy_target: RTL and testbench
==================================

// Module: mdio_phy_target
// PURPOSE
//  MDIO target (PHY-side management slave) sitting directly downstream of the MDIO controller.
//  Samples the controller's mdc/mdio_oe/mdio_out, decodes Clause-22 style 32-bit frames.
//  Services writes/reads on a local 16-bit register file and drives read data back on mdio_in.
//  Frame bits, MSB first: ST[2]=01 | OP[2] (01 write, 10 read) | PHYAD[5] | REGAD[5] | TA[2] | DATA[16].
// PARAMETERS
//  PHY_ADDR   5'd1       PHYAD this target answers to
//  NUM_REGS   32         implemented registers 0..NUM_REGS-1 (4..32)
//  ID1        16'h0141   read-only value of register 2
//  ID2        16'h0CC2   read-only value of register 3
// PORTS
//  clk         in   1   system clock; mdc is derived from it
//  reset       in   1   synchronous, active-low
//  mdc         in   1   management clock from controller
//  mdio_oe     in   1   1 = controller drives mdio_out
//  mdio_out    in   1   serial data from controller
//  mdio_in     out  1   serial read data to controller; 0 when not driving
//  mdio_drive  out  1   1 while target owns the line (TA bit 2 + 16 data bits)
//  wr_strobe   out  1   one-clk pulse on committed write
//  wr_addr     out  5   register address of the committed write
//  wr_data     out  16  data of the committed write
//  busy        out  1   1 from accepted ST until frame end/abort
// BEHAVIOUR
//  - Reset (reset==0 at posedge clk): state IDLE, bit counter 0, all outputs 0, regs 0 except 2=ID1, 3=ID2.
//  - Reset mid-frame aborts immediately; no write commits, mdio_drive drops next edge.
//  - Edge detect: mdc_q <= mdc each clk; rise = mdc & ~mdc_q, fall = ~mdc & mdc_q.
//  - Sampling: mdio_out sampled only in a rise cycle with mdio_oe==1; rises with mdio_oe==0 ignored in IDLE/HDR.
//  - Bit counter n = 1..32 counts rises from ST[1]; 5-bit+wrap-free, cleared on return to IDLE.
//  - States: IDLE -> HDR -> TA -> (WDATA | RDATA | SKIP) -> IDLE.
//    IDLE: sampled 0 -> HDR (n=1). Sampled 1 -> stay.
//    HDR: n=2 must be 1 else IDLE (bad ST). OP 00/11 -> IDLE at n=4. Collect PHYAD, REGAD to n=14.
//    At n=14: PHYAD!=PHY_ADDR -> SKIP; else TA. Read: snapshot reg[REGAD] (0 if REGAD>=NUM_REGS).
//    TA (n=15,16): rises counted regardless of mdio_oe; write TA values not checked.
//    RDATA: on fall after n=15: mdio_drive=1, mdio_in=0. On fall after n=k (16..31): mdio_in=D[31-k].
//           On fall after n=32: mdio_drive=0, mdio_in=0, -> IDLE. mdio_in/mdio_drive change only in fall cycles.
//    WDATA: shift bits n=17..32; on rise n=32 commit: reg write if REGAD<NUM_REGS and REGAD not 2/3.
//           wr_strobe=1 next clk for one clk for every matched write (incl. read-only/out-of-range), wr_addr/wr_data held until next commit.
//    SKIP: count to n=32, no drive, no strobe -> IDLE.
//  - busy=1 in HDR/TA/WDATA/RDATA/SKIP; 0 in IDLE.
//  - Back-to-back frames: ST[1] may be sampled on the rise immediately after n=32.
//  - Latency: read data bit valid at mdio_in one clk after mdc fall; controller samples on next rise.
// CONFIGURATION
//  MDIO_PREAMBLE_EN defined: IDLE requires >=32 consecutive sampled 1s (counter saturates at 32)
//   before a 0 is taken as ST[1]; a 0 with count<32 clears the count and is ignored.
//  Not defined: first sampled 0 in IDLE starts a frame; no preamble needed.
// TESTING
//  1 write frame 01_01_00001_00000_10_A5A5 -> wr_strobe 1 clk, wr_addr=0, wr_data=16'hA5A5; read reg0 returns A5A5.
//  2 read frame 01_10_00001_00010_ZZ -> mdio_drive 17 bits, mdio_in = 0 then 16'h0141 MSB first.
//  3 write to PHYAD 5'd7 then read reg0 -> no wr_strobe, mdio_drive stays 0 during bad frame; reg0 unchanged.
//  4 ST=00 or OP=11 frame -> busy drops by n=2/n=4, no strobe, no drive; next valid frame decoded.
//  5 reset low at n=20 of write to reg1 -> reg1 stays 0, busy=0, mdio_in=0; following read of reg1 returns 0.
//  6 read REGAD=5'd31 with NUM_REGS=8 -> data 16'h0000; write reg3 16'hFFFF -> strobe, read reg3 = ID2.

Source files
------------

// File: rtl/mdio_phy_target_if.sv
// MDIO target bus: controller-driven line signals, target read-back, write-commit
// sideband and FSM state for observation.
interface mdio_phy_target_if;
    logic        mdc;
    logic        mdio_oe;
    logic        mdio_out;
    logic        mdio_in;
    logic        mdio_drive;
    logic        wr_strobe;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic [2:0]  state_dbg;

    // wr_strobe is a one-cycle valid with no ready: wr_addr/wr_data are valid in the
    // strobe cycle and held until the next commit; the consumer must take it then.
    modport master (
        output mdc, mdio_oe, mdio_out,
        input  mdio_in, mdio_drive, wr_strobe, wr_addr, wr_data, busy, state_dbg
    );

    modport slave (
        input  mdc, mdio_oe, mdio_out,
        output mdio_in, mdio_drive, wr_strobe, wr_addr, wr_data, busy, state_dbg
    );
endinterface

// File: rtl/mdio_phy_target.sv
// Clause-22 MDIO management target with a small local register file.
// Define MDIO_PREAMBLE_EN to require a 32-bit all-ones preamble before each frame.
module mdio_phy_target #(
    parameter logic [4:0]  PHY_ADDR = 5'd1,
    parameter int          NUM_REGS = 32,
    parameter logic [15:0] ID1      = 16'h0141,
    parameter logic [15:0] ID2      = 16'h0CC2
) (
    input  logic              clk,
    input  logic              reset,
    mdio_phy_target_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_TA    = 3'd2,
        S_WDATA = 3'd3,
        S_RDATA = 3'd4,
        S_SKIP  = 3'd5
    } state_t;

    state_t      state;
    logic        mdc_q;
    logic [5:0]  n;
    logic [10:0] hdr_sh;
    logic [14:0] wr_sh;
    logic [15:0] rd_word;
    logic [4:0]  reg_addr;
    logic        is_read;
    logic [15:0] regs [NUM_REGS];
    logic        mdio_in_r;
    logic        mdio_drive_r;
    logic        wr_strobe_r;
    logic [4:0]  wr_addr_r;
    logic [15:0] wr_data_r;
`ifdef MDIO_PREAMBLE_EN
    logic [5:0]  pre_cnt;
`endif

    logic        rise;
    logic        fall;
    logic        bit_in;
    logic [5:0]  n_nxt;
    logic [11:0] hdr;
    logic [15:0] w_word;
    logic [15:0] rd_sel;
    logic [3:0]  rd_idx;

    assign rise   = bus.mdc & ~mdc_q;
    assign fall   = ~bus.mdc & mdc_q;
    assign bit_in = bus.mdio_out;
    assign n_nxt  = n + 6'd1;
    // Header as it stands after the current bit: OP[11:10] PHYAD[9:5] REGAD[4:0] at n=14.
    assign hdr    = {hdr_sh, bit_in};
    assign w_word = {wr_sh, bit_in};
    assign rd_idx = 4'(5'd31 - n[4:0]);

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (hdr[4:0] == 5'(i)) rd_sel = regs[i];
        end
    end

    always_ff @(posedge clk) begin
        mdc_q <= bus.mdc;
        if (!reset) begin
            state        <= S_IDLE;
            n            <= '0;
            hdr_sh       <= '0;
            wr_sh        <= '0;
            rd_word      <= '0;
            reg_addr     <= '0;
            is_read      <= 1'b0;
            mdio_in_r    <= 1'b0;
            mdio_drive_r <= 1'b0;
            wr_strobe_r  <= 1'b0;
            wr_addr_r    <= '0;
            wr_data_r    <= '0;
`ifdef MDIO_PREAMBLE_EN
            pre_cnt      <= '0;
`endif
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i == 2)      regs[i] <= ID1;
                else if (i == 3) regs[i] <= ID2;
                else             regs[i] <= '0;
            end
        end else begin
            wr_strobe_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rise && bus.mdio_oe) begin
`ifdef MDIO_PREAMBLE_EN
                        if (bit_in) begin
                            pre_cnt <= (pre_cnt == 6'd32) ? pre_cnt : pre_cnt + 6'd1;
                        end else begin
                            pre_cnt <= '0;
                            if (pre_cnt == 6'd32) begin
                                state <= S_HDR;
                                n     <= 6'd1;
                            end
                        end
`else
                        if (!bit_in) begin
                            state <= S_HDR;
                            n     <= 6'd1;
                        end
`endif
                    end
                end
                S_HDR: begin
                    if (rise && bus.mdio_oe) begin
                        n      <= n_nxt;
                        hdr_sh <= hdr[10:0];
                        if (n_nxt == 6'd2 && !bit_in) begin
                            state <= S_IDLE;
                            n     <= '0;
                        end else if (n_nxt == 6'd4 && (hdr[1:0] == 2'b00 || hdr[1:0] == 2'b11)) begin
                            state <= S_IDLE;
                            n     <= '0;
                        end else if (n_nxt == 6'd14) begin
                            reg_addr <= hdr[4:0];
                            is_read  <= (hdr[11:10] == 2'b10);
                            rd_word  <= rd_sel;
                            state    <= (hdr[9:5] == PHY_ADDR) ? S_TA : S_SKIP;
                        end
                    end
                end
                S_TA: begin
                    if (rise) begin
                        n <= n_nxt;
                        if (n_nxt == 6'd16) state <= is_read ? S_RDATA : S_WDATA;
                    end else if (fall && is_read && n == 6'd15) begin
                        mdio_drive_r <= 1'b1;
                        mdio_in_r    <= 1'b0;
                    end
                end
                S_WDATA: begin
                    if (rise) begin
                        n     <= n_nxt;
                        wr_sh <= w_word[14:0];
                        if (n_nxt == 6'd32) begin
                            wr_strobe_r <= 1'b1;
                            wr_addr_r   <= reg_addr;
                            wr_data_r   <= w_word;
                            state       <= S_IDLE;
                            n           <= '0;
                            // Registers 2/3 are read-only IDs; out-of-range addresses match nothing.
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (reg_addr == 5'(i) && i != 2 && i != 3) regs[i] <= w_word;
                            end
                        end
                    end
                end
                S_RDATA: begin
                    if (rise) begin
                        if (n != 6'd32) n <= n_nxt;
                    end else if (fall) begin
                        if (n == 6'd32) begin
                            mdio_drive_r <= 1'b0;
                            mdio_in_r    <= 1'b0;
                            state        <= S_IDLE;
                            n            <= '0;
                        end else begin
                            mdio_in_r <= rd_word[rd_idx];
                        end
                    end
                end
                S_SKIP: begin
                    if (rise) begin
                        n <= n_nxt;
                        if (n_nxt == 6'd32) begin
                            state <= S_IDLE;
                            n     <= '0;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    n     <= '0;
                end
            endcase
        end
    end

    assign bus.mdio_in    = mdio_in_r;
    assign bus.mdio_drive = mdio_drive_r;
    assign bus.wr_strobe  = wr_strobe_r;
    assign bus.wr_addr    = wr_addr_r;
    assign bus.wr_data    = wr_data_r;
    assign bus.busy       = (state != S_IDLE);
    assign bus.state_dbg  = state;

endmodule

// File: tb/tb_mdio_phy_target.sv
// Bench for mdio_phy_target: bit-level MDIO controller driver, register-file model
// and a write-commit scoreboard; built with NUM_REGS=8 to reach out-of-range addresses.
module tb_mdio_phy_target;
    localparam logic [4:0]  PHY   = 5'd1;
    localparam int          NREGS = 8;
    localparam logic [15:0] ID1   = 16'h0141;
    localparam logic [15:0] ID2   = 16'h0CC2;
    localparam logic [1:0]  OP_WR = 2'b01;
    localparam logic [1:0]  OP_RD = 2'b10;
    localparam logic [31:0] DRV_RD = 32'hFFFF_8000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    logic [20:0] exp_q[$];
    logic [20:0] sb_e;
    logic [15:0] mregs [32];
    logic [15:0] t_rd;
    logic        t_ta;
    logic [31:0] t_drv;

    mdio_phy_target_if bus();

    mdio_phy_target #(.PHY_ADDR(PHY), .NUM_REGS(NREGS), .ID1(ID1), .ID2(ID2)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "watchdog");
    end

    // Every committed write must match the oldest expected commit.
    always @(negedge clk) begin
        if (reset && bus.wr_strobe === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL strobe_unexpected: got addr=%0d data=%h, required no strobe", bus.wr_addr, bus.wr_data);
            end else begin
                sb_e = exp_q.pop_front();
                if ({bus.wr_addr, bus.wr_data} !== sb_e) begin
                    miscompares++;
                    $display("FAIL strobe_payload: got addr=%0d data=%h, required addr=%0d data=%h",
                             bus.wr_addr, bus.wr_data, sb_e[20:16], sb_e[15:0]);
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = 16'h0000;
        mregs[2] = ID1;
        mregs[3] = ID2;
        exp_q.delete();
    endtask

    function automatic logic [15:0] model_read(input logic [4:0] a);
        return (int'(a) < NREGS) ? mregs[a] : 16'h0000;
    endfunction

    task automatic model_write(input logic [4:0] phy, input logic [4:0] a, input logic [15:0] d);
        if (phy == PHY) begin
            exp_q.push_back({a, d});
            if (int'(a) < NREGS && a != 5'd2 && a != 5'd3) mregs[a] = d;
        end
    endtask

    // One MDC period: low phase with new data, sample the line just before the rise.
    task automatic mdc_bit(input logic oe, input logic val, output logic rbit, output logic rdrv);
        @(negedge clk);
        bus.mdc = 1'b0;
        bus.mdio_oe = oe;
        bus.mdio_out = val;
        repeat (3) @(negedge clk);
        rbit = bus.mdio_in;
        rdrv = bus.mdio_drive;
        bus.mdc = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic idle_bits(input int k);
        logic b, d;
        for (int i = 0; i < k; i++) mdc_bit(1'b1, 1'b1, b, d);
    endtask

    task automatic send_frame(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] a,
                              input logic [15:0] d, input int nbits,
                              output logic [15:0] rd, output logic ta0, output logic [31:0] drv);
        logic [31:0] f;
        logic b, dv, rdop, oe_b;
        rdop = (op == OP_RD);
        f = {2'b01, op, phy, a, 2'b10, d};
        rd = '0;
        ta0 = 1'b1;
        drv = '0;
        for (int i = 1; i <= nbits; i++) begin
            oe_b = !(rdop && i >= 15);
            mdc_bit(oe_b, f[32 - i], b, dv);
            drv[i - 1] = dv;
            if (i == 16) ta0 = b;
            if (i >= 17) rd = {rd[14:0], b};
        end
    endtask

    task automatic do_write(input logic [4:0] phy, input logic [4:0] a, input logic [15:0] d);
        logic [15:0] r;
        logic t;
        idle_bits(32);
        model_write(phy, a, d);
        send_frame(OP_WR, phy, a, d, 32, r, t, t_drv);
        idle_bits(1);
    endtask

    task automatic do_read(input logic [4:0] phy, input logic [4:0] a);
        idle_bits(32);
        send_frame(OP_RD, phy, a, 16'h0000, 32, t_rd, t_ta, t_drv);
        idle_bits(1);
    endtask

    task automatic test_reset();
        bus.mdc = 1'b0;
        bus.mdio_oe = 1'b1;
        bus.mdio_out = 1'b1;
        reset = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
        vectors++;
        if (bus.mdio_drive !== 1'b0 || bus.mdio_in !== 1'b0) begin
            miscompares++; $display("FAIL reset_line: got drive=%b in=%b, required 0 0", bus.mdio_drive, bus.mdio_in);
        end
        vectors++;
        if ({bus.wr_strobe, bus.wr_addr, bus.wr_data} !== 22'd0) begin
            miscompares++; $display("FAIL reset_wr: got strobe=%b addr=%0d data=%h, required all 0", bus.wr_strobe, bus.wr_addr, bus.wr_data);
        end
    endtask

    task automatic test_write_read();
        do_write(PHY, 5'd0, 16'hA5A5);
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL wr0_strobe: got %0d pending commits, required 0", exp_q.size()); end
        vectors++;
        if (bus.wr_addr !== 5'd0 || bus.wr_data !== 16'hA5A5) begin
            miscompares++; $display("FAIL wr0_hold: got addr=%0d data=%h, required 0 a5a5", bus.wr_addr, bus.wr_data);
        end
        do_read(PHY, 5'd0);
        vectors++;
        if (t_rd !== model_read(5'd0)) begin miscompares++; $display("FAIL rd0_data: got %h, required %h", t_rd, model_read(5'd0)); end
        vectors++;
        if (t_drv !== DRV_RD) begin miscompares++; $display("FAIL rd0_drive: got %h, required %h", t_drv, DRV_RD); end
    endtask

    task automatic test_id_read();
        do_read(PHY, 5'd2);
        vectors++;
        if (t_rd !== 16'h0141) begin miscompares++; $display("FAIL id1_data: got %h, required 0141", t_rd); end
        vectors++;
        if (t_ta !== 1'b0 || t_drv !== DRV_RD) begin
            miscompares++; $display("FAIL id1_turnaround: got ta=%b drive=%h, required 0 %h", t_ta, t_drv, DRV_RD);
        end
        vectors++;
        if (bus.mdio_drive !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++; $display("FAIL id1_release: got drive=%b busy=%b, required 0 0", bus.mdio_drive, bus.busy);
        end
        do_read(PHY, 5'd3);
        vectors++;
        if (t_rd !== model_read(5'd3)) begin miscompares++; $display("FAIL id2_data: got %h, required %h", t_rd, model_read(5'd3)); end
    endtask

    task automatic test_wrong_phy();
        do_write(5'd7, 5'd0, 16'h1234);
        do_read(5'd7, 5'd0);
        vectors++;
        if (t_drv !== 32'd0 || t_rd !== 16'h0000) begin
            miscompares++; $display("FAIL phy7_silent: got drive=%h data=%h, required 0 0", t_drv, t_rd);
        end
        do_read(PHY, 5'd0);
        vectors++;
        if (t_rd !== model_read(5'd0)) begin miscompares++; $display("FAIL phy7_reg0: got %h, required %h", t_rd, model_read(5'd0)); end
    endtask

    task automatic test_bad_frames();
        logic b, d;
        logic any_drv;
        any_drv = 1'b0;
        idle_bits(32);
        mdc_bit(1'b1, 1'b0, b, d); any_drv |= d;
        vectors++;
        if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL st_busy1: got %b, required 1", bus.busy); end
        mdc_bit(1'b1, 1'b0, b, d); any_drv |= d;
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL st00_abort: got busy=%b, required 0", bus.busy); end
        for (int k = 0; k < 2; k++) begin
            idle_bits(32);
            mdc_bit(1'b1, 1'b0, b, d); any_drv |= d;
            mdc_bit(1'b1, 1'b1, b, d); any_drv |= d;
            mdc_bit(1'b1, (k == 0), b, d); any_drv |= d;
            vectors++;
            if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL op_busy3: got %b, required 1", bus.busy); end
            mdc_bit(1'b1, (k == 0), b, d); any_drv |= d;
            vectors++;
            if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL op_abort: got busy=%b, required 0 (op %0d)", bus.busy, k); end
        end
        idle_bits(4);
        do_read(PHY, 5'd3);
        vectors++;
        if (t_rd !== ID2 || any_drv !== 1'b0 || exp_q.size() != 0) begin
            miscompares++; $display("FAIL bad_then_good: got data=%h drive_seen=%b commits=%0d, required %h 0 0", t_rd, any_drv, exp_q.size(), ID2);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] r;
        logic t;
        logic [31:0] dv;
        idle_bits(32);
        send_frame(OP_WR, PHY, 5'd1, 16'h5A3C, 20, r, t, dv);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0 || bus.mdio_in !== 1'b0 || bus.wr_strobe !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid_wr: got busy=%b in=%b strobe=%b, required 0 0 0", bus.busy, bus.mdio_in, bus.wr_strobe);
        end
        reset = 1'b1;
        model_reset();
        idle_bits(32);
        send_frame(OP_RD, PHY, 5'd2, 16'h0000, 20, r, t, dv);
        vectors++;
        if (bus.mdio_drive !== 1'b1) begin miscompares++; $display("FAIL rst_mid_rd_pre: got drive=%b, required 1", bus.mdio_drive); end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.mdio_drive !== 1'b0 || bus.mdio_in !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid_rd_drop: got drive=%b in=%b, required 0 0", bus.mdio_drive, bus.mdio_in);
        end
        @(negedge clk);
        reset = 1'b1;
        do_read(PHY, 5'd1);
        vectors++;
        if (t_rd !== model_read(5'd1)) begin miscompares++; $display("FAIL rst_reg1: got %h, required %h", t_rd, model_read(5'd1)); end
        do_read(PHY, 5'd0);
        vectors++;
        if (t_rd !== model_read(5'd0)) begin miscompares++; $display("FAIL rst_reg0: got %h, required %h", t_rd, model_read(5'd0)); end
    endtask

    task automatic test_out_of_range();
        do_read(PHY, 5'd31);
        vectors++;
        if (t_rd !== 16'h0000 || t_drv !== DRV_RD) begin
            miscompares++; $display("FAIL oor_read: got data=%h drive=%h, required 0000 %h", t_rd, t_drv, DRV_RD);
        end
        do_write(PHY, 5'd3, 16'hFFFF);
        do_write(PHY, 5'd9, 16'hBEEF);
        do_write(PHY, 5'(NREGS - 1), 16'h7E57);
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL oor_strobes: got %0d pending commits, required 0", exp_q.size()); end
        do_read(PHY, 5'd3);
        vectors++;
        if (t_rd !== ID2) begin miscompares++; $display("FAIL ro_reg3: got %h, required %h", t_rd, ID2); end
        do_read(PHY, 5'd9);
        vectors++;
        if (t_rd !== model_read(5'd9)) begin miscompares++; $display("FAIL oor_reg9: got %h, required %h", t_rd, model_read(5'd9)); end
        do_read(PHY, 5'(NREGS - 1));
        vectors++;
        if (t_rd !== model_read(5'(NREGS - 1))) begin miscompares++; $display("FAIL last_reg: got %h, required %h", t_rd, model_read(5'(NREGS - 1))); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d, r1, r2;
        logic t1, t2;
        logic [31:0] v1, v2;
        d = 16'($urandom);
        idle_bits(32);
        model_write(PHY, 5'd5, d);
        send_frame(OP_WR, PHY, 5'd5, d, 32, r1, t1, v1);
        send_frame(OP_RD, PHY, 5'd5, 16'h0000, 32, r1, t1, v1);
        send_frame(OP_RD, PHY, 5'd2, 16'h0000, 32, r2, t2, v2);
        idle_bits(1);
        vectors++;
        if (r1 !== model_read(5'd5) || v1 !== DRV_RD) begin
            miscompares++; $display("FAIL b2b_first: got data=%h drive=%h, required %h %h", r1, v1, model_read(5'd5), DRV_RD);
        end
        vectors++;
        if (r2 !== ID1 || t2 !== 1'b0 || v2 !== DRV_RD) begin
            miscompares++; $display("FAIL b2b_second: got data=%h ta=%b drive=%h, required %h 0 %h", r2, t2, v2, ID1, DRV_RD);
        end
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL b2b_strobe: got %0d pending commits, required 0", exp_q.size()); end
    endtask

    task automatic test_random();
        logic [4:0] phy, a;
        logic [15:0] d, exp_rd;
        logic [31:0] exp_drv;
        for (int k = 0; k < 24; k++) begin
            phy = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : PHY;
            a = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, NREGS - 1));
            d = 16'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                do_write(phy, a, d);
                vectors++;
                if (exp_q.size() != 0) begin
                    miscompares++; $display("FAIL rnd_write: got %0d pending commits, required 0 (phy=%0d reg=%0d)", exp_q.size(), phy, a);
                end
            end else begin
                exp_rd  = (phy == PHY) ? model_read(a) : 16'h0000;
                exp_drv = (phy == PHY) ? DRV_RD : 32'd0;
                do_read(phy, a);
                vectors++;
                if (t_rd !== exp_rd || t_drv !== exp_drv) begin
                    miscompares++;
                    $display("FAIL rnd_read: got data=%h drive=%h, required %h %h (phy=%0d reg=%0d)", t_rd, t_drv, exp_rd, exp_drv, phy, a);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_id_read();
        test_wrong_phy();
        test_bad_frames();
        test_reset_mid();
        test_out_of_range();
        test_back_to_back();
        test_random();
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
